fifo_read_adapter: RTL and testbench

FIFO_READ_ADAPTER -- requirements
Module: fifo_read_adapter

---
 rtl/fifo_read_adapter.sv | 77 +++++++
 tb/tb_fifo_read_adapter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_adapter.sv
// Turns a registered-output FIFO read port into a valid/ready stream.
// Keeps a two-entry skid buffer so that a read already in flight always has a slot to land in.
module fifo_read_adapter #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   async_rst,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   fifo_read,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic [COUNT_WIDTH-1:0] word_count,
   output logic                   busy
);

   logic [1:0]            occ;
   logic [1:0]            occ_next;
   logic                  inflight;
   logic                  startup;
   logic                  pop;
   logic [DATA_WIDTH-1:0] tail;

   assign pop      = m_valid && m_ready;
   assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};
   assign busy     = (occ != 2'd0) || inflight;

   // A new read may only be issued if the word it returns is guaranteed a slot.
   // The startup flag holds the strobe low for the first cycle after reset.
   assign fifo_read = !fifo_empty && !startup && (occ_next < 2'd2);

   // m_data is the buffer head and tail is the second slot.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         occ        <= 2'd0;
         inflight   <= 1'b0;
         startup    <= 1'b1;
         m_valid    <= 1'b0;
         m_data     <= '0;
         tail       <= '0;
         word_count <= '0;
      end else begin
         startup  <= 1'b0;
         inflight <= fifo_read;
         occ      <= occ_next;
         m_valid  <= (occ_next != 2'd0);
         if (pop) begin
            word_count <= word_count + COUNT_WIDTH'(1);
         end
         case ({inflight, pop})
            2'b01: begin
               m_data <= tail;
            end
            2'b10: begin
               if (occ == 2'd0) begin
                  m_data <= fifo_rd_data;
               end else begin
                  tail <= fifo_rd_data;
               end
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  m_data <= fifo_rd_data;
               end else begin
                  m_data <= tail;
                  tail   <= fifo_rd_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: a queue-based FIFO model feeds the DUT and a scoreboard checks the stream.
// A second instance with a 4-bit counter shares the same stimulus.
module tb_fifo_read_adapter;

   logic        clk;
   logic        async_rst;
   logic        fifo_empty;
   logic [7:0]  fifo_rd_data;
   logic        m_ready;
   logic        fifo_read, m_valid, busy;
   logic [7:0]  m_data;
   logic [15:0] word_count;
   logic        fifo_read4, m_valid4, busy4;
   logic [7:0]  m_data4;
   logic [3:0]  word_count4;

   logic [7:0] src_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] pend_word;
   bit         pend_valid;
   int         held;
   bit         last_read;
   bit         prev_hold;
   logic [7:0] prev_data;
   logic [7:0] last_popped;
   int         n_pops, n_reads, cyc, read_cyc, first_pop_cyc, last_pop_cyc;
   int         compared, mismatched;

   fifo_read_adapter dut (
      .clk(clk), .async_rst(async_rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
      .fifo_read(fifo_read), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .word_count(word_count), .busy(busy)
   );

   fifo_read_adapter #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
      .clk(clk), .async_rst(async_rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
      .fifo_read(fifo_read4), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
      .word_count(word_count4), .busy(busy4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // One clock of stimulus; expectations come from word accounting:
   // held = words read but not yet delivered, last_read = a word is still on its way.
   task automatic cycle(input bit rdy, input bit stall);
      bit         exp_valid, exp_rd, exp_pop, act_pop;
      logic [7:0] want;
      @(negedge clk);
      cyc++;
      fifo_rd_data = pend_valid ? pend_word : 8'($urandom);
      pend_valid   = 1'b0;
      m_ready      = rdy;
      fifo_empty   = (src_q.size() == 0) || stall;
      #1;
      exp_valid = (held - int'(last_read)) > 0;
      exp_pop   = exp_valid && rdy;
      exp_rd    = !fifo_empty && ((held - int'(exp_pop)) < 2);
      compared++;
      if (fifo_read === 1'b1 && fifo_empty) begin
         mismatched++;
         $display("[TB] FAIL read_while_empty cycle %0d: fifo_read=%b fifo_empty=%b", cyc, fifo_read, fifo_empty);
      end
      compared++;
      if (m_valid !== exp_valid || m_valid4 !== exp_valid) begin
         mismatched++;
         $display("[TB] FAIL m_valid cycle %0d: got %b/%b expected %b", cyc, m_valid, m_valid4, exp_valid);
      end
      compared++;
      if (busy !== (held != 0) || busy4 !== (held != 0)) begin
         mismatched++;
         $display("[TB] FAIL busy cycle %0d: got %b/%b expected %b", cyc, busy, busy4, held != 0);
      end
      compared++;
      if (fifo_read !== exp_rd || fifo_read4 !== exp_rd) begin
         mismatched++;
         $display("[TB] FAIL fifo_read cycle %0d: got %b/%b expected %b", cyc, fifo_read, fifo_read4, exp_rd);
      end
      compared++;
      if (word_count !== 16'(n_pops) || word_count4 !== 4'(n_pops)) begin
         mismatched++;
         $display("[TB] FAIL word_count cycle %0d: got %0d/%0d expected %0d", cyc, word_count, word_count4, n_pops);
      end
      if (prev_hold) begin
         compared++;
         if (m_valid !== 1'b1 || m_data !== prev_data) begin
            mismatched++;
            $display("[TB] FAIL stall_stable cycle %0d: got %b/%h expected 1/%h", cyc, m_valid, m_data, prev_data);
         end
      end
      if (fifo_read === 1'b1 && src_q.size() > 0) begin
         pend_word  = src_q.pop_front();
         pend_valid = 1'b1;
         exp_q.push_back(pend_word);
         read_cyc = cyc;
         n_reads++;
      end
      act_pop = (m_valid === 1'b1) && rdy;
      if (act_pop) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL pop_underflow cycle %0d: got %h expected no word", cyc, m_data);
         end else begin
            want = exp_q.pop_front();
            if (m_data !== want || m_data4 !== want) begin
               mismatched++;
               $display("[TB] FAIL m_data cycle %0d: got %h/%h expected %h", cyc, m_data, m_data4, want);
            end
         end
         n_pops++;
         last_popped  = m_data;
         last_pop_cyc = cyc;
         if (n_pops == 1) first_pop_cyc = cyc;
      end
      held      = held + int'(fifo_read === 1'b1) - int'(act_pop);
      last_read = (fifo_read === 1'b1);
      prev_hold = (m_valid === 1'b1) && !rdy;
      prev_data = m_data;
   endtask

   // Asserts reset asynchronously, checks outputs at once, releases on a falling edge
   // and presents any killed in-flight word while the strobe must stay low.
   task automatic pulse_reset();
      async_rst = 1'b1;
      #1;
      compared++;
      if (fifo_read !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || word_count !== 16'h0000 ||
          busy !== 1'b0 || word_count4 !== 4'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got rd=%b v=%b d=%h wc=%h busy=%b wc4=%h expected all zero",
                  fifo_read, m_valid, m_data, word_count, busy, word_count4);
      end
      exp_q.delete();
      held      = 0;
      last_read = 1'b0;
      n_pops    = 0;
      prev_hold = 1'b0;
      repeat (2) @(negedge clk);
      async_rst    = 1'b0;
      m_ready      = 1'b1;
      fifo_empty   = (src_q.size() == 0);
      fifo_rd_data = pend_valid ? pend_word : 8'hC3;
      pend_valid   = 1'b0;
      #1;
      compared++;
      if (fifo_read !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL read_after_release: got %b expected 0", fifo_read);
      end
   endtask

   task automatic test_reset();
      pulse_reset();
      repeat (3) cycle(1'b1, 1'b0);
   endtask

   task automatic test_single_word();
      pulse_reset();
      src_q.push_back(8'hA5);
      for (int i = 0; i < 12 && n_pops < 1; i++) cycle(1'b1, 1'b0);
      compared++;
      if (n_pops != 1) begin
         mismatched++;
         $display("[TB] FAIL single_timeout: got %0d words expected 1", n_pops);
      end
      compared++;
      if (last_pop_cyc - read_cyc != 2) begin
         mismatched++;
         $display("[TB] FAIL single_latency: got %0d cycles expected 2", last_pop_cyc - read_cyc);
      end
      cycle(1'b1, 1'b0);
      compared++;
      if (word_count !== 16'd1) begin
         mismatched++;
         $display("[TB] FAIL single_count: got %0d expected 1", word_count);
      end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
      for (int i = 0; i < 60 && n_pops < 16; i++) cycle(1'b1, 1'b0);
      compared++;
      if (n_pops != 16) begin
         mismatched++;
         $display("[TB] FAIL b2b_timeout: got %0d words expected 16", n_pops);
      end
      compared++;
      if (last_pop_cyc - first_pop_cyc != 15) begin
         mismatched++;
         $display("[TB] FAIL b2b_span: got %0d cycles expected 15", last_pop_cyc - first_pop_cyc);
      end
      cycle(1'b1, 1'b0);
      compared++;
      if (busy !== 1'b0 || word_count !== 16'd16) begin
         mismatched++;
         $display("[TB] FAIL b2b_end: got busy=%b wc=%0d expected busy=0 wc=16", busy, word_count);
      end
   endtask

   task automatic test_count_wrap();
      src_q.push_back(8'h10);
      for (int i = 0; i < 10 && n_pops < 17; i++) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      compared++;
      if (word_count4 !== 4'd1 || word_count !== 16'd17) begin
         mismatched++;
         $display("[TB] FAIL count_wrap: got wc4=%0d wc=%0d expected 1 and 17", word_count4, word_count);
      end
   endtask

   task automatic test_backpressure();
      int reads0;
      pulse_reset();
      for (int i = 0; i < 8; i++) src_q.push_back(8'h20 + 8'(i));
      reads0 = n_reads;
      repeat (10) cycle(1'b0, 1'b0);
      compared++;
      if (n_reads - reads0 > 2) begin
         mismatched++;
         $display("[TB] FAIL bp_reads: got %0d reads expected at most 2", n_reads - reads0);
      end
      for (int i = 0; i < 40 && n_pops < 8; i++) cycle(1'b1, 1'b0);
      compared++;
      if (n_pops != 8 || exp_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL bp_drain: got %0d words (%0d pending) expected 8 (0)", n_pops, exp_q.size());
      end
   endtask

   task automatic test_reset_inflight();
      pulse_reset();
      for (int i = 0; i < 4; i++) src_q.push_back(8'h40 + 8'(i));
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      @(negedge clk);
      #1;
      compared++;
      if (busy !== 1'b1 || m_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL pre_reset_state: got busy=%b v=%b expected 1/1", busy, m_valid);
      end
      pulse_reset();
      for (int i = 0; i < 10 && n_pops < 1; i++) cycle(1'b1, 1'b0);
      compared++;
      if (n_pops != 1 || last_popped !== 8'h42) begin
         mismatched++;
         $display("[TB] FAIL first_after_reset: got %0d words first=%h expected 1 word 42", n_pops, last_popped);
      end
      for (int i = 0; i < 10 && n_pops < 2; i++) cycle(1'b1, 1'b0);
   endtask

   task automatic test_random();
      pulse_reset();
      for (int i = 0; i < 1000; i++) src_q.push_back(8'($urandom));
      for (int i = 0; i < 20000 && n_pops < 1000; i++)
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      compared++;
      if (n_pops != 1000 || exp_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL random_drain: got %0d words (%0d pending) expected 1000 (0)", n_pops, exp_q.size());
      end
   endtask

   initial begin
      async_rst    = 1'b0;
      fifo_empty   = 1'b1;
      fifo_rd_data = 8'h00;
      m_ready      = 1'b0;
      pend_valid   = 1'b0;
      pend_word    = 8'h00;
      prev_data    = 8'h00;
      last_popped  = 8'h00;
      held = 0; last_read = 1'b0; prev_hold = 1'b0;
      n_pops = 0; n_reads = 0; cyc = 0; read_cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0;
      compared = 0; mismatched = 0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_count_wrap();
      test_backpressure();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
